arb_mux_kto1_wn: RTL and testbench

//   K-channel, N-bit registered multiplexer with valid/ready handshake per channel. Arbitrates

---
 rtl/arb_mux_pkg.sv | 20 ++
 rtl/rr_arbiter_k.sv | 46 ++++
 rtl/arb_mux_kto1_wn.sv | 86 ++++++++
 tb/tb_arb_mux_kto1_wn.sv | 174 +++++++++++++++++
 4 files changed

// File: rtl/arb_mux_pkg.sv
`default_nettype none
// ============================================================================
// Module      : arb_mux_pkg
// Description : Shared constants and helpers for the K-to-1 arbitrated mux.
// Revision    : 1.0
// ============================================================================
package arb_mux_pkg;

    localparam logic MODE_FIXED = 1'b0;
    localparam logic MODE_RR    = 1'b1;

    // An index field for a single channel still needs one bit.
    function automatic int clog2_floor1(input int value);
        int r;
        r = $clog2(value);
        return (r < 1) ? 1 : r;
    endfunction

endpackage
`default_nettype wire

// File: rtl/rr_arbiter_k.sv
`default_nettype none
// ============================================================================
// Module      : rr_arbiter_k
// Description : Combinational K-way arbiter, round-robin or fixed priority.
// Revision    : 1.0
// ============================================================================
module rr_arbiter_k
    import arb_mux_pkg::*;
#(
    parameter int K  = 4,
    parameter int SW = clog2_floor1(K)
) (
    input  logic [K-1:0]  req,
    input  logic [SW-1:0] ptr,
    input  logic          rr_en,
    output logic [K-1:0]  grant,
    output logic [SW-1:0] gidx
);

    logic [K-1:0]   w_mask;
    logic [2*K-1:0] w_dbl;
    logic           w_found;

    always_comb begin
        w_mask = '0;
        for (int i = 0; i < K; i++) begin
            w_mask[i] = (rr_en == MODE_FIXED) || (i >= int'(ptr));
        end
        // Lower copy holds requests at/above the pointer, upper copy supplies the wrap.
        w_dbl   = {req, req & w_mask};
        w_found = 1'b0;
        gidx    = '0;
        for (int i = 2 * K - 1; i >= 0; i--) begin
            if (w_dbl[i]) begin
                w_found = 1'b1;
                gidx    = SW'(i % K);
            end
        end
        grant = '0;
        for (int i = 0; i < K; i++) begin
            grant[i] = w_found && (int'(gidx) == i);
        end
    end

endmodule
`default_nettype wire

// File: rtl/arb_mux_kto1_wn.sv
`default_nettype none
// ============================================================================
// Module      : arb_mux_kto1_wn
// Description : K-channel N-bit arbitrated mux with one registered output slot.
// Revision    : 1.0
// ============================================================================
module arb_mux_kto1_wn
    import arb_mux_pkg::*;
#(
    parameter  int N  = 4,
    parameter  int K  = 4,
    localparam int SW = clog2_floor1(K)
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic           rr_en,
    input  logic [K*N-1:0] in_data,
    input  logic [K-1:0]   in_valid,
    output logic [K-1:0]   in_ready,
    output logic [N-1:0]   out_data,
    output logic [SW-1:0]  out_sel,
    output logic           out_valid,
    input  logic           out_ready
);

    logic [K-1:0]  w_grant;
    logic [SW-1:0] w_gidx;
    logic [SW-1:0] w_ptr_next;
    logic [N-1:0]  w_word;
    logic          w_load_en;
    logic          w_xfer;
    logic [SW-1:0] r_ptr;
    logic [N-1:0]  r_out_data;
    logic [SW-1:0] r_out_sel;
    logic          r_out_valid;

    rr_arbiter_k #(
        .K  (K),
        .SW (SW)
    ) u_arb (
        .req   (in_valid),
        .ptr   (r_ptr),
        .rr_en (rr_en),
        .grant (w_grant),
        .gidx  (w_gidx)
    );

    assign w_load_en  = !r_out_valid || out_ready;
    assign in_ready   = rst_n ? (w_grant & {K{w_load_en}}) : '0;
    assign w_xfer     = |in_ready;
    assign w_ptr_next = (int'(w_gidx) == K - 1) ? '0 : w_gidx + 1'b1;

    always_comb begin
        w_word = '0;
        for (int i = 0; i < K; i++) begin
            if (int'(w_gidx) == i) begin
                w_word = in_data[i*N +: N];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_out_valid <= 1'b0;
            r_out_data  <= '0;
            r_out_sel   <= '0;
            r_ptr       <= '0;
        end else if (w_xfer) begin
            r_out_valid <= 1'b1;
            r_out_data  <= w_word;
            r_out_sel   <= w_gidx;
            if (rr_en == MODE_RR) begin
                r_ptr <= w_ptr_next;
            end
        end else if (r_out_valid && out_ready) begin
            // Data and index keep their last value once consumed.
            r_out_valid <= 1'b0;
        end
    end

    assign out_data  = r_out_data;
    assign out_sel   = r_out_sel;
    assign out_valid = r_out_valid;

endmodule
`default_nettype wire

// File: tb/tb_arb_mux_kto1_wn.sv
`default_nettype none
// ============================================================================
// Module      : tb_arb_mux_kto1_wn
// Description : Directed vector table plus randomized run against a reference model.
// Revision    : 1.0
// ============================================================================
module tb_arb_mux_kto1_wn;

    localparam int N  = 4;
    localparam int K  = 4;
    localparam int SW = 2;
    localparam logic [K*N-1:0] C_DATA = 16'hDCBA;

    logic           clk = 1'b0;
    logic           rst_n;
    logic           rr_en;
    logic [K*N-1:0] in_data;
    logic [K-1:0]   in_valid;
    logic [K-1:0]   in_ready;
    logic [N-1:0]   out_data;
    logic [SW-1:0]  out_sel;
    logic           out_valid;
    logic           out_ready;

    int total = 0;
    int bad   = 0;

    // Reference model state: what the single output slot should hold.
    int       m_ptr   = 0;
    bit       m_valid = 1'b0;
    int       m_sel   = 0;
    int       m_data  = 0;
    logic [K-1:0] m_exp_rdy;
    logic [K-1:0] seen_rdy;

    arb_mux_kto1_wn #(.N(N), .K(K)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .rr_en     (rr_en),
        .in_data   (in_data),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .out_data  (out_data),
        .out_sel   (out_sel),
        .out_valid (out_valid),
        .out_ready (out_ready)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s got=%0h want=%0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic int pick(input bit rr, input logic [K-1:0] v);
        for (int k = 0; k < K; k++) begin
            int c;
            c = rr ? (m_ptr + k) % K : k;
            if (v[c]) return c;
        end
        return -1;
    endfunction

    // One clock: drive inputs, sample in_ready mid-cycle, step model, land 1 time unit after the edge.
    task automatic apply(input bit r, input bit rr, input logic [K-1:0] v, input bit ordy,
                         input logic [K*N-1:0] d);
        int  g;
        bit  le;
        rst_n = r; rr_en = rr; in_valid = v; out_ready = ordy; in_data = d;
        g  = pick(rr, v);
        le = !m_valid || ordy;
        m_exp_rdy = (r && le && g >= 0) ? K'(1 << g) : '0;
        #1;
        seen_rdy = in_ready;
        @(posedge clk);
        if (!r) begin
            m_valid = 0; m_data = 0; m_sel = 0; m_ptr = 0;
        end else if (g >= 0 && le) begin
            m_valid = 1;
            m_data  = int'(d[g*N +: N]);
            m_sel   = g;
            if (rr) m_ptr = (g + 1) % K;
        end else if (m_valid && ordy) begin
            m_valid = 0;
        end
        #1;
    endtask

    typedef struct {
        bit           rst_n;
        bit           rr;
        logic [K-1:0] v;
        bit           ordy;
        logic [K-1:0] rdy;
        bit           ov;
        int           sel;
        logic [N-1:0] od;
    } vec_t;

    vec_t tbl[26];

    initial begin
        // reset held two cycles with all channels requesting
        tbl[0]  = '{1'b0, 1'b1, 4'hF, 1'b1, 4'h0, 1'b0, 0, 4'h0};
        tbl[1]  = '{1'b0, 1'b1, 4'hF, 1'b1, 4'h0, 1'b0, 0, 4'h0};
        // round-robin fairness, one word per cycle
        tbl[2]  = '{1'b1, 1'b1, 4'hF, 1'b1, 4'b0001, 1'b1, 0, 4'hA};
        tbl[3]  = '{1'b1, 1'b1, 4'hF, 1'b1, 4'b0010, 1'b1, 1, 4'hB};
        tbl[4]  = '{1'b1, 1'b1, 4'hF, 1'b1, 4'b0100, 1'b1, 2, 4'hC};
        tbl[5]  = '{1'b1, 1'b1, 4'hF, 1'b1, 4'b1000, 1'b1, 3, 4'hD};
        tbl[6]  = '{1'b1, 1'b1, 4'hF, 1'b1, 4'b0001, 1'b1, 0, 4'hA};
        // backpressure: three stalled cycles, then release continues at channel 1
        tbl[7]  = '{1'b1, 1'b1, 4'hF, 1'b0, 4'h0, 1'b1, 0, 4'hA};
        tbl[8]  = '{1'b1, 1'b1, 4'hF, 1'b0, 4'h0, 1'b1, 0, 4'hA};
        tbl[9]  = '{1'b1, 1'b1, 4'hF, 1'b0, 4'h0, 1'b1, 0, 4'hA};
        tbl[10] = '{1'b1, 1'b1, 4'hF, 1'b1, 4'b0010, 1'b1, 1, 4'hB};
        // fixed priority: channel 3 starved, then served once channel 1 drops
        tbl[11] = '{1'b1, 1'b0, 4'b1010, 1'b1, 4'b0010, 1'b1, 1, 4'hB};
        tbl[12] = '{1'b1, 1'b0, 4'b1010, 1'b1, 4'b0010, 1'b1, 1, 4'hB};
        tbl[13] = '{1'b1, 1'b0, 4'b1010, 1'b1, 4'b0010, 1'b1, 1, 4'hB};
        tbl[14] = '{1'b1, 1'b0, 4'b1000, 1'b1, 4'b1000, 1'b1, 3, 4'hD};
        // pointer was held at 2 in fixed mode; channel 2 moves it to 3, then sparse wrap
        tbl[15] = '{1'b1, 1'b1, 4'b0100, 1'b1, 4'b0100, 1'b1, 2, 4'hC};
        tbl[16] = '{1'b1, 1'b1, 4'b0101, 1'b1, 4'b0001, 1'b1, 0, 4'hA};
        tbl[17] = '{1'b1, 1'b1, 4'b0101, 1'b1, 4'b0100, 1'b1, 2, 4'hC};
        tbl[18] = '{1'b1, 1'b1, 4'b0101, 1'b1, 4'b0001, 1'b1, 0, 4'hA};
        tbl[19] = '{1'b1, 1'b1, 4'b0101, 1'b1, 4'b0100, 1'b1, 2, 4'hC};
        // drain: valid falls, data/sel hold
        tbl[20] = '{1'b1, 1'b1, 4'b0000, 1'b1, 4'h0, 1'b0, 2, 4'hC};
        tbl[21] = '{1'b1, 1'b1, 4'b0000, 1'b1, 4'h0, 1'b0, 2, 4'hC};
        // load then stall, then reset mid-stall; pointer must restart at 0
        tbl[22] = '{1'b1, 1'b1, 4'b0010, 1'b0, 4'b0010, 1'b1, 1, 4'hB};
        tbl[23] = '{1'b1, 1'b1, 4'b0010, 1'b0, 4'h0, 1'b1, 1, 4'hB};
        tbl[24] = '{1'b0, 1'b1, 4'hF, 1'b0, 4'h0, 1'b0, 0, 4'h0};
        tbl[25] = '{1'b1, 1'b1, 4'b1001, 1'b1, 4'b0001, 1'b1, 0, 4'hA};

        rst_n = 1'b0; rr_en = 1'b1; in_valid = '0; out_ready = 1'b0; in_data = C_DATA;
        @(posedge clk); #1;

        for (int i = 0; i < 26; i++) begin
            apply(tbl[i].rst_n, tbl[i].rr, tbl[i].v, tbl[i].ordy, C_DATA);
            chk($sformatf("vec%0d in_ready", i), 32'(seen_rdy), 32'(tbl[i].rdy));
            chk($sformatf("vec%0d out_valid", i), 32'(out_valid), 32'(tbl[i].ov));
            chk($sformatf("vec%0d out_sel", i), 32'(out_sel), 32'(tbl[i].sel));
            chk($sformatf("vec%0d out_data", i), 32'(out_data), 32'(tbl[i].od));
        end

        // randomized traffic against the model, including occasional resets and mode flips
        for (int c = 0; c < 3000; c++) begin
            bit           r, rr, ordy;
            logic [K-1:0] v;
            logic [K*N-1:0] d;
            r    = ($urandom_range(0, 59) != 0);
            rr   = ($urandom_range(0, 3) != 0);
            v    = K'($urandom);
            ordy = ($urandom_range(0, 9) < 7);
            d    = (K*N)'($urandom);
            apply(r, rr, v, ordy, d);
            chk("rand in_ready", 32'(seen_rdy), 32'(m_exp_rdy));
            chk("rand out_valid", 32'(out_valid), 32'(m_valid));
            chk("rand out_sel", 32'(out_sel), 32'(m_sel));
            chk("rand out_data", 32'(out_data), 32'(m_data));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
